// File: rtl/fetch_stage.sv
// IF stage of the P5 MIPS pipeline plus the IF/ID register.
// IF->ID latency is 1 cycle. stall freezes the PC and IF/ID. Branches use a delay slot and nothing is flushed.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic        j_en,
  input  logic        jr_en,
  input  logic        cmp_eq,
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_index26,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] im_instr,
  output logic [31:0] im_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc8,
  output logic        if_id_adel
);

  localparam logic [31:0] IM_LAST = RESET_PC + 32'(IM_WORDS * 4) - 32'd4;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc8_q, ifid_pc8_d;
  logic        adel_q, adel_d;

  logic [31:0] id_pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] next_pc;
  logic        fetch_err;

  // Branch and jump targets are relative to the instruction in ID, not to the current PC.
  assign id_pc_plus4 = id_pc + 32'd4;
  assign br_offset   = {{14{id_imm16[15]}}, id_imm16, 2'b00};
  assign br_target   = id_pc_plus4 + br_offset;
  assign j_target    = {id_pc_plus4[31:28], id_index26, 2'b00};

  assign fetch_err = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) || (pc_q > IM_LAST);

  always_comb begin
    next_pc = pc_q + 32'd4;
    if (jr_en) begin
      next_pc = id_rs_data;
    end else if (j_en) begin
      next_pc = j_target;
    end else if (branch && cmp_eq) begin
      next_pc = br_target;
    end
  end

  always_comb begin
    pc_d       = next_pc;
    ifid_pc_d  = pc_q;
    ifid_pc8_d = pc_q + 32'd8;
    instr_d    = fetch_err ? 32'd0 : im_instr;
    adel_d     = fetch_err;
    // A stalled ID keeps the same control instruction, so the redirect is re-evaluated later.
    if (stall) begin
      pc_d       = pc_q;
      ifid_pc_d  = ifid_pc_q;
      ifid_pc8_d = ifid_pc8_q;
      instr_d    = instr_q;
      adel_d     = adel_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      ifid_pc_q  <= RESET_PC;
      ifid_pc8_q <= RESET_PC + 32'd8;
      adel_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      ifid_pc_q  <= ifid_pc_d;
      ifid_pc8_q <= ifid_pc8_d;
      adel_q     <= adel_d;
    end
  end

  assign im_addr     = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifid_pc_q;
  assign if_id_pc8   = ifid_pc8_q;
  assign if_id_adel  = adel_q;

  a_jr_j_exclusive: assert property (@(posedge clk) disable iff (reset) !(jr_en && j_en));

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded directed test for fetch_stage: stimulus pushes expected post-edge state, monitor checks at negedge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch, j_en, jr_en, cmp_eq;
  logic [31:0] id_pc, id_rs_data, im_instr;
  logic [15:0] id_imm16;
  logic [25:0] id_index26;
  logic [31:0] im_addr, if_id_instr, if_id_pc, if_id_pc8;
  logic        if_id_adel;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .branch     (branch),
    .j_en       (j_en),
    .jr_en      (jr_en),
    .cmp_eq     (cmp_eq),
    .id_pc      (id_pc),
    .id_imm16   (id_imm16),
    .id_index26 (id_index26),
    .id_rs_data (id_rs_data),
    .im_instr   (im_instr),
    .im_addr    (im_addr),
    .if_id_instr(if_id_instr),
    .if_id_pc   (if_id_pc),
    .if_id_pc8  (if_id_pc8),
    .if_id_adel (if_id_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Monitor: every negedge, compare the state the previous edge should have produced.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("im_addr",     e.id, im_addr,          e.addr);
      chk("if_id_instr", e.id, if_id_instr,      e.instr);
      chk("if_id_pc",    e.id, if_id_pc,         e.pc);
      chk("if_id_pc8",   e.id, if_id_pc8,        e.pc8);
      chk("if_id_adel",  e.id, {31'd0, if_id_adel}, {31'd0, e.adel});
    end
  end

  int step = 0;

  // Drive one cycle, record expected post-edge state, advance to just past the next negedge.
  task automatic cyc(input logic stl, input logic br, input logic j, input logic jr, input logic eq,
                     input logic [31:0] ipc, input logic [15:0] imm, input logic [25:0] idx,
                     input logic [31:0] rs, input logic [31:0] ins,
                     input logic [31:0] e_addr, input logic [31:0] e_instr,
                     input logic [31:0] e_pc, input logic [31:0] e_pc8, input logic e_adel);
    exp_t e;
    stall = stl; branch = br; j_en = j; jr_en = jr; cmp_eq = eq;
    id_pc = ipc; id_imm16 = imm; id_index26 = idx; id_rs_data = rs; im_instr = ins;
    step++;
    e.id = step; e.addr = e_addr; e.instr = e_instr; e.pc = e_pc; e.pc8 = e_pc8; e.adel = e_adel;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic plain(input logic [31:0] ins, input logic [31:0] e_addr, input logic [31:0] e_instr,
                       input logic [31:0] e_pc, input logic [31:0] e_pc8, input logic e_adel);
    cyc(0, 0, 0, 0, 0, 32'd0, 16'd0, 26'd0, 32'd0, ins, e_addr, e_instr, e_pc, e_pc8, e_adel);
  endtask

  task automatic jr_to(input logic [31:0] rs, input logic [31:0] ins, input logic [31:0] e_addr,
                       input logic [31:0] e_instr, input logic [31:0] e_pc, input logic [31:0] e_pc8,
                       input logic e_adel);
    cyc(0, 0, 0, 1, 0, 32'h0000_3100, 16'd0, 26'd0, rs, ins, e_addr, e_instr, e_pc, e_pc8, e_adel);
  endtask

  initial begin
    reset = 1'b1; stall = 0; branch = 0; j_en = 0; jr_en = 0; cmp_eq = 0;
    id_pc = 0; id_imm16 = 0; id_index26 = 0; id_rs_data = 0; im_instr = 32'h3421_0001;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst im_addr", 0, im_addr,     32'h0000_3000);
    chk("rst instr",   0, if_id_instr, 32'h0000_0000);
    chk("rst pc",      0, if_id_pc,    32'h0000_3000);
    chk("rst pc8",     0, if_id_pc8,   32'h0000_3008);
    chk("rst adel",    0, {31'd0, if_id_adel}, 32'd0);
    reset = 1'b0;

    // Sequential fetch.
    plain(32'h3421_0001, 32'h3004, 32'h3421_0001, 32'h3000, 32'h3008, 0);
    plain(32'h3421_0001, 32'h3008, 32'h3421_0001, 32'h3004, 32'h300C, 0);
    plain(32'h3421_0001, 32'h300C, 32'h3421_0001, 32'h3008, 32'h3010, 0);
    plain(32'h3C01_300C, 32'h3010, 32'h3C01_300C, 32'h300C, 32'h3014, 0);
    plain(32'h1000_FFFC, 32'h3014, 32'h1000_FFFC, 32'h3010, 32'h3018, 0);
    // Taken beq at 0x3010: delay slot 0x3014 latched, redirect to 0x3004.
    cyc(0, 1, 0, 0, 1, 32'h3010, 16'hFFFC, 26'd0, 32'd0, 32'h2402_0005,
        32'h3004, 32'h2402_0005, 32'h3014, 32'h301C, 0);
    plain(32'hA000_3004, 32'h3008, 32'hA000_3004, 32'h3004, 32'h300C, 0);
    plain(32'hA000_3008, 32'h300C, 32'hA000_3008, 32'h3008, 32'h3010, 0);
    plain(32'hA000_300C, 32'h3010, 32'hA000_300C, 32'h300C, 32'h3014, 0);
    plain(32'h1000_FFFC, 32'h3014, 32'h1000_FFFC, 32'h3010, 32'h3018, 0);
    // Untaken beq.
    cyc(0, 1, 0, 0, 0, 32'h3010, 16'hFFFC, 26'd0, 32'd0, 32'h2402_0005,
        32'h3018, 32'h2402_0005, 32'h3014, 32'h301C, 0);
    plain(32'hA000_3018, 32'h301C, 32'hA000_3018, 32'h3018, 32'h3020, 0);
    plain(32'hA000_301C, 32'h3020, 32'hA000_301C, 32'h301C, 32'h3024, 0);
    plain(32'h0C00_0C10, 32'h3024, 32'h0C00_0C10, 32'h3020, 32'h3028, 0);
    // jal at 0x3020 -> 0x3040.
    cyc(0, 1, 1, 0, 0, 32'h3020, 16'h0C10, 26'h000_0C10, 32'd0, 32'h2403_0007,
        32'h3040, 32'h2403_0007, 32'h3024, 32'h302C, 0);
    plain(32'h03E0_0008, 32'h3044, 32'h03E0_0008, 32'h3040, 32'h3048, 0);
    // jr with branch also high -> 0x3100.
    cyc(0, 1, 0, 1, 0, 32'h3040, 16'h0008, 26'd0, 32'h3100, 32'h2404_0009,
        32'h3100, 32'h2404_0009, 32'h3044, 32'h304C, 0);
    plain(32'hA000_3100, 32'h3104, 32'hA000_3100, 32'h3100, 32'h3108, 0);
    // jr without branch to a misaligned address.
    jr_to(32'h3102, 32'hA000_3104, 32'h3102, 32'hA000_3104, 32'h3104, 32'h310C, 0);
    plain(32'hDEAD_BEEF, 32'h3106, 32'h0, 32'h3102, 32'h310A, 1);
    plain(32'hDEAD_BEEF, 32'h310A, 32'h0, 32'h3106, 32'h310E, 1);
    jr_to(32'h3000, 32'hDEAD_BEEF, 32'h3000, 32'h0, 32'h310A, 32'h3112, 1);
    plain(32'hA000_3000, 32'h3004, 32'hA000_3000, 32'h3000, 32'h3008, 0);
    // Lower range bound.
    jr_to(32'h2FFC, 32'hA000_3004, 32'h2FFC, 32'hA000_3004, 32'h3004, 32'h300C, 0);
    plain(32'hDEAD_BEEF, 32'h3000, 32'h0, 32'h2FFC, 32'h3004, 1);
    // Upper range bound: 0x3FFC valid, 0x4000 not.
    jr_to(32'h3FFC, 32'hA000_3000, 32'h3FFC, 32'hA000_3000, 32'h3000, 32'h3008, 0);
    plain(32'hA000_3FFC, 32'h4000, 32'hA000_3FFC, 32'h3FFC, 32'h4004, 0);
    plain(32'hDEAD_BEEF, 32'h4004, 32'h0, 32'h4000, 32'h4008, 1);
    // Wrap at the top of the address space.
    jr_to(32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0, 32'h4004, 32'h400C, 1);
    plain(32'hDEAD_BEEF, 32'h0000_0000, 32'h0, 32'hFFFF_FFFC, 32'h0000_0004, 1);
    jr_to(32'h3000, 32'hDEAD_BEEF, 32'h3000, 32'h0, 32'h0000_0000, 32'h0000_0008, 1);
    plain(32'hA000_3000, 32'h3004, 32'hA000_3000, 32'h3000, 32'h3008, 0);
    // Stall for two edges with a taken beq in ID, then release.
    cyc(1, 1, 0, 0, 1, 32'h3000, 16'h0010, 26'd0, 32'd0, 32'hA000_3004,
        32'h3004, 32'hA000_3000, 32'h3000, 32'h3008, 0);
    cyc(1, 1, 0, 0, 1, 32'h3000, 16'h0010, 26'd0, 32'd0, 32'hA000_3004,
        32'h3004, 32'hA000_3000, 32'h3000, 32'h3008, 0);
    cyc(0, 1, 0, 0, 1, 32'h3000, 16'h0010, 26'd0, 32'd0, 32'hA000_3004,
        32'h3044, 32'hA000_3004, 32'h3004, 32'h300C, 0);

    // Asynchronous reset mid-cycle while stalled.
    stall = 1'b1; branch = 0; cmp_eq = 0; im_instr = 32'hA000_3044;
    @(posedge clk);
    #2;
    chk("pre-rst pc", 100, if_id_pc, 32'h3004);
    reset = 1'b1;
    #1;
    chk("async rst im_addr", 100, im_addr,     32'h0000_3000);
    chk("async rst instr",   100, if_id_instr, 32'h0000_0000);
    chk("async rst pc",      100, if_id_pc,    32'h0000_3000);
    chk("async rst pc8",     100, if_id_pc8,   32'h0000_3008);
    chk("async rst adel",    100, {31'd0, if_id_adel}, 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    chk("post-rst im_addr", 101, im_addr, 32'h0000_3000);
    plain(32'hA000_3000, 32'h3004, 32'hA000_3000, 32'h3000, 32'h3008, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard drained", 999, 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
